// File: rtl/mult_buf_pkg.sv
// mult_buf_pkg: shared types and helpers for the multiply/block-buffer slice
package mult_buf_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;
  function automatic int prod_w(input int in_w);
    return 2 * in_w;
  endfunction
endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: MUL_STAGES-deep multiplier pipeline carrying a valid bit with the product
// Ports: clk, rst (sync, active-low); i_valid/i_a/i_b operand pair in;
//        o_valid/o_prod product out MUL_STAGES cycles later; o_busy = any stage holds a valid pair.
// Build option: SIGNED_MULT_EN selects a two's-complement multiply (default unsigned).
module mult_pipe
  import mult_buf_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [IN_W-1:0]           i_a,
  input  logic [IN_W-1:0]           i_b,
  output logic                      o_valid,
  output logic [prod_w(IN_W)-1:0]   o_prod,
  output logic                      o_busy
);
  localparam int PW = prod_w(IN_W);
`ifdef SIGNED_MULT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic [MUL_STAGES-1:0] r_vld;
  logic [PW-1:0]         r_prod [MUL_STAGES];
  logic [PW-1:0]         w_a, w_b, w_prod;
  // Extending both operands to the full product width makes the truncated
  // product correct for either signedness.
  assign w_a    = {{IN_W{SGN & i_a[IN_W-1]}}, i_a};
  assign w_b    = {{IN_W{SGN & i_b[IN_W-1]}}, i_b};
  assign w_prod = w_a * w_b;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < MUL_STAGES; i++) r_prod[i] <= '0;
    end else begin
      r_vld     <= MUL_STAGES'({r_vld, i_valid});
      r_prod[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) r_prod[i] <= r_prod[i-1];
    end
  end
  assign o_valid = r_vld[MUL_STAGES-1];
  assign o_prod  = r_prod[MUL_STAGES-1];
  assign o_busy  = |r_vld;
endmodule

// File: rtl/mult_block_buffer.sv
// mult_block_buffer: multiplies operand pairs into a RAM block and streams the block back on request
// Ports: clk, rst (sync, active-low);
//        EN_mult/mult_input0/mult_input1/RDY_mult  operand handshake;
//        EN_writeMem/writeMem_addr/writeMem_val    RAM write port;
//        EN_blockRead                              read-out request;
//        EN_readMem/readMem_addr/readMem_val       RAM read port (RD_LAT cycles);
//        VALID_memVal/memVal_data                  streamed products; count = products held or in flight.
// Build option: SIGNED_MULT_EN selects a signed multiply.
module mult_block_buffer
  import mult_buf_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int MUL_STAGES = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    EN_mult,
  input  logic [IN_W-1:0]         mult_input0,
  input  logic [IN_W-1:0]         mult_input1,
  output logic                    RDY_mult,
  output logic                    EN_writeMem,
  output logic [ADDR_W-1:0]       writeMem_addr,
  output logic [prod_w(IN_W)-1:0] writeMem_val,
  input  logic                    EN_blockRead,
  output logic                    EN_readMem,
  output logic [ADDR_W-1:0]       readMem_addr,
  input  logic [prod_w(IN_W)-1:0] readMem_val,
  output logic                    VALID_memVal,
  output logic [prod_w(IN_W)-1:0] memVal_data,
  output logic [ADDR_W:0]         count
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  state_t              r_state, w_next;
  logic [ADDR_W:0]     r_count, r_rd, r_vcnt;
  logic [ADDR_W-1:0]   r_wptr;
  logic                r_pend;
  logic [RD_LAT-1:0]   r_rlat;
  logic                w_acc, w_busy, w_go, w_last;
  assign RDY_mult = rst && (r_state == IDLE || r_state == FILL) && r_count < FULL_CNT && !r_pend;
  assign w_acc    = EN_mult && RDY_mult;
  // The drain may only start once no pair is entering or inside the pipeline,
  // so every counted product is in RAM before it is read back.
  assign w_go     = (EN_blockRead || r_pend) && r_state != DRAIN && r_count != '0 && !w_acc && !w_busy;
  assign w_last   = VALID_memVal && r_vcnt == r_count - 1'b1;
  assign EN_readMem    = r_state == DRAIN && r_rd < r_count;
  assign readMem_addr  = r_rd[ADDR_W-1:0];
  assign writeMem_addr = r_wptr;
  assign count         = r_count;
  mult_pipe #(.IN_W(IN_W), .MUL_STAGES(MUL_STAGES)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_acc),
    .i_a     (mult_input0),
    .i_b     (mult_input1),
    .o_valid (EN_writeMem),
    .o_prod  (writeMem_val),
    .o_busy  (w_busy)
  );
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = w_go ? DRAIN :
             r_state == DRAIN ? (w_last ? IDLE : DRAIN) :
             w_acc ? ((r_count + 1'b1 == FULL_CNT) ? FULL : FILL) : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count      <= '0;
      r_wptr       <= '0;
      r_rd         <= '0;
      r_vcnt       <= '0;
      r_pend       <= 1'b0;
      r_rlat       <= '0;
      VALID_memVal <= 1'b0;
      memVal_data  <= '0;
    end else begin
      // A request seen while products are still in flight is remembered and
      // also closes the accept window.
      r_pend       <= !w_go && (r_pend || (EN_blockRead && r_state != DRAIN && (r_count != '0 || w_acc)));
      r_rlat       <= RD_LAT'({r_rlat, EN_readMem});
      VALID_memVal <= r_rlat[RD_LAT-1];
      if (r_rlat[RD_LAT-1]) memVal_data <= readMem_val;
      if (w_last) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rd    <= '0;
        r_vcnt  <= '0;
      end else begin
        if (w_acc)        r_count <= r_count + 1'b1;
        if (EN_writeMem)  r_wptr  <= r_wptr + 1'b1;
        if (EN_readMem)   r_rd    <= r_rd + 1'b1;
        if (VALID_memVal) r_vcnt  <= r_vcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_block_buffer.sv
// tb_mult_block_buffer: self-checking bench with a transaction-level model of the block buffer
module tb_mult_block_buffer;
  localparam int DEPTH = 64, MS = 2, RL = 1;
  logic        clk = 0, rst = 0, EN_mult = 0, EN_blockRead = 0;
  logic [15:0] a = 0, b = 0;
  logic        RDY_mult, EN_writeMem, EN_readMem, VALID_memVal;
  logic [5:0]  writeMem_addr, readMem_addr;
  logic [31:0] writeMem_val, memVal_data, readMem_val = 0;
  logic [6:0]  count;
  int total = 0, bad = 0, cyc = 0, vcnt = 0;

  mult_block_buffer dut (
    .clk(clk), .rst(rst), .EN_mult(EN_mult), .mult_input0(a), .mult_input1(b),
    .RDY_mult(RDY_mult), .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr),
    .writeMem_val(writeMem_val), .EN_blockRead(EN_blockRead), .EN_readMem(EN_readMem),
    .readMem_addr(readMem_addr), .readMem_val(readMem_val), .VALID_memVal(VALID_memVal),
    .memVal_data(memVal_data), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (EN_writeMem) ram[writeMem_addr] <= writeMem_val;
    if (EN_readMem) readMem_val <= ram[readMem_addr];
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mprod(logic [15:0] x, logic [15:0] y);
`ifdef SIGNED_MULT_EN
    return 32'(longint'($signed(x)) * longint'($signed(y)));
`else
    return 32'(longint'(x) * longint'(y));
`endif
  endfunction

  // Transaction model: accepted pairs become scheduled writes; a block read
  // replays the block contents in order after the pipeline has emptied.
  typedef struct { int due; int addr; logic [31:0] val; } wr_t;
  wr_t         wq[$];
  logic [31:0] blk[$];
  int          m_cnt = 0, d_start = 0, d_n = 0;
  bit          m_req = 0, m_drain = 0;

  always @(negedge clk) begin
    bit exp_rdy, acc, busy, req_now, popped;
    int t, k;
    if (!rst) begin
      chk("rdy_in_reset", RDY_mult, 0);
      wq.delete(); blk.delete();
      m_cnt = 0; m_req = 0; m_drain = 0;
    end else begin
      chk("count", count, m_cnt);
      exp_rdy = !m_drain && !m_req && m_cnt < DEPTH;
      chk("rdy", RDY_mult, exp_rdy);
      acc = EN_mult && exp_rdy;
      popped = 0;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        chk("wr_en", EN_writeMem, 1);
        chk("wr_addr", writeMem_addr, wq[0].addr);
        chk("wr_val", writeMem_val, wq[0].val);
        void'(wq.pop_front());
        popped = 1;
      end else chk("wr_quiet", EN_writeMem, 0);
      busy = popped || wq.size() > 0;
      if (acc) begin
        wq.push_back('{cyc + MS, m_cnt, mprod(a, b)});
        blk.push_back(mprod(a, b));
        m_cnt++;
      end
      if (m_drain) begin
        t = cyc - d_start;
        chk("rd_en", EN_readMem, t < d_n);
        if (t < d_n) chk("rd_addr", readMem_addr, t);
        k = t - RL - 1;
        chk("beat_vld", VALID_memVal, k >= 0 && k < d_n);
        if (k >= 0 && k < d_n) chk("beat_data", memVal_data, blk[k]);
        if (k == d_n - 1) begin
          m_drain = 0; m_cnt = 0; blk.delete();
        end
      end else begin
        chk("rd_quiet", EN_readMem, 0);
        chk("beat_quiet", VALID_memVal, 0);
        req_now = m_req || (EN_blockRead && m_cnt > 0);
        if (req_now && !acc && !busy) begin
          m_drain = 1; d_start = cyc + 1; d_n = m_cnt; m_req = 0;
        end else m_req = req_now;
      end
    end
  end

  typedef struct { int c; int addr; logic [31:0] val; } wl_t;
  wl_t wlog[$];
  always @(negedge clk) begin
    if (rst && EN_writeMem) wlog.push_back('{cyc, writeMem_addr, writeMem_val});
    if (rst && VALID_memVal) vcnt++;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((m_drain || m_req) && w < 400) begin step(1); w++; end
    chk("idle_timeout", w < 400, 1);
  endtask

  task automatic do_drain(int n);
    int v0 = vcnt;
    EN_blockRead = 1; step(1); EN_blockRead = 0;
    wait_idle();
    chk("drain_beats", vcnt - v0, n);
    @(negedge clk);
    chk("drain_count0", count, 0);
    chk("drain_rdy", RDY_mult, 1);
    step(1);
  endtask

  typedef struct { logic [15:0] a, b; logic [31:0] p; } vec_t;
  vec_t tbl[4];
  int   acc_c[4];

  initial begin
`ifdef SIGNED_MULT_EN
    tbl = '{'{16'd3, 16'd4, 32'd12}, '{16'hFFFF, 16'hFFFF, 32'h1},
            '{16'd0, 16'd7, 32'd0}, '{16'hFFFD, 16'd5, 32'hFFFFFFF1}};
`else
    tbl = '{'{16'd3, 16'd4, 32'd12}, '{16'hFFFF, 16'hFFFF, 32'hFFFE0001},
            '{16'd0, 16'd7, 32'd0}, '{16'hFFFD, 16'd5, 32'h0004FFF1}};
`endif
    step(2); rst = 1;
    @(negedge clk);
    chk("rst_rdy", RDY_mult, 1);
    chk("rst_outs", {EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr,
                     VALID_memVal, memVal_data, count}, 0);
    step(1);

    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      EN_mult = 1; a = tbl[i].a; b = tbl[i].b; acc_c[i] = cyc; step(1);
    end
    EN_mult = 0; step(4);
    chk("tbl_count", count, 4);
    chk("tbl_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("tbl_addr", wlog[i].addr, i);
      chk("tbl_val", wlog[i].val, tbl[i].p);
      chk("tbl_lat", wlog[i].c - acc_c[i], MS);
    end
    do_drain(4);

    EN_blockRead = 1; step(1); EN_blockRead = 0; step(3);
    chk("empty_read_ignored", {EN_readMem, RDY_mult}, 2'b01);

    wlog.delete();
    for (int i = 0; i < DEPTH + 5; i++) begin
      EN_mult = 1; a = 16'($urandom); b = 16'($urandom); step(1);
    end
    EN_mult = 0;
    @(negedge clk);
    chk("full_rdy", RDY_mult, 0);
    chk("full_count", count, DEPTH);
    step(3);
    chk("full_nwr", wlog.size(), DEPTH);
    if (wlog.size() == DEPTH) begin
      chk("full_first", wlog[0].addr, 0);
      chk("full_last", wlog[DEPTH-1].addr, DEPTH - 1);
    end
    do_drain(DEPTH);

    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      EN_mult = 1; a = 16'($urandom); b = 16'($urandom); step(1);
    end
    EN_mult = 0; step(4);
    chk("five_first_addr", wlog.size() > 0 ? wlog[0].addr : -1, 0);
    do_drain(5);

    for (int i = 0; i < 3; i++) begin
      EN_mult = 1; a = 16'(i + 9); b = 16'hBEEF; step(1);
    end
    EN_mult = 1; EN_blockRead = 1; a = 16'h1234; b = 16'h5678; step(1);
    EN_mult = 0; EN_blockRead = 0;
    begin
      int v0 = vcnt - 0;
      v0 = vcnt;
      wait_idle();
      chk("same_edge_beats", vcnt - v0, 4);
    end
    step(1);

    EN_mult = 1; a = 16'd100; b = 16'd200; step(2);
    EN_mult = 0; rst = 0; step(1); rst = 1;
    wlog.delete();
    @(negedge clk);
    chk("midrst_outs", {EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr,
                        VALID_memVal, memVal_data, count}, 0);
    step(4);
    chk("midrst_nowr", wlog.size(), 0);
    EN_mult = 1; a = 16'd6; b = 16'd7; step(1); EN_mult = 0; step(3);
    chk("midrst_addr0", wlog.size() == 1 ? wlog[0].addr : -1, 0);
    do_drain(1);

    for (int i = 0; i < 2500; i++) begin
      EN_mult      = $urandom_range(0, 3) != 0;
      EN_blockRead = $urandom_range(0, 60) == 0;
      rst          = $urandom_range(0, 700) != 0;
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF; 1: a = 16'h8000; default: a = 16'($urandom);
      endcase
      b = $urandom_range(0, 4) == 0 ? 16'h0 : 16'($urandom);
      step(1);
    end
    EN_mult = 0; EN_blockRead = 0; rst = 1; step(MS + 1);
    wait_idle();
    if (m_cnt > 0) do_drain(m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/mult_block_buffer.md
Name: mult_block_buffer

Overview:
- Parametrised successor to the single-product multiply/write FSM.
- Accepts operand pairs through a ready/enable handshake and multiplies them in a configurable pipeline.
- Writes each product to consecutive addresses of an external synchronous RAM.
- On request, streams the stored block back out in address order, then frees the buffer for the next block.
- Sits between the operand source and the product RAM; also serves as the read-out path to the consumer.

Parameters:
- IN_W, 16, operand width in bits; product width is 2*IN_W.
- DEPTH, 64, number of RAM entries (products per block); must be ≥ 2.
- ADDR_W, $clog2(DEPTH), RAM address width.
- MUL_STAGES, 2, multiplier pipeline depth in cycles; must be ≥ 1.
- RD_LAT, 1, external RAM read latency in cycles (readMem_addr → readMem_val).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- EN_mult  in  1  operand pair valid.
- mult_input0  in  IN_W  operand A.
- mult_input1  in  IN_W  operand B.
- RDY_mult  out  1  block can accept an operand pair this cycle.
- EN_writeMem  out  1  RAM write strobe.
- writeMem_addr  out  ADDR_W  RAM write address.
- writeMem_val  out  2*IN_W  RAM write data (product).
- EN_blockRead  in  1  request read-out of the stored block.
- EN_readMem  out  1  RAM read strobe.
- readMem_addr  out  ADDR_W  RAM read address.
- readMem_val  in  2*IN_W  RAM read data.
- VALID_memVal  out  1  memVal_data valid.
- memVal_data  out  2*IN_W  streamed product.
- count  out  ADDR_W+1  products committed or in flight.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all strobes, addresses, data outputs, count and pipeline valids = 0.
  - RDY_mult=0 during the reset cycle, 1 from the first cycle after.
  - Reset mid-operation discards in-flight products and read-out; no write or read strobe is issued afterwards.
- States (state_t, 2 bits): IDLE, FILL, FULL, DRAIN.
- Accept: a pair is taken on a clk edge where EN_mult=1 and RDY_mult=1. EN_mult while RDY_mult=0 is ignored; nothing is queued.
- RDY_mult = (state is IDLE or FILL) and count < DEPTH. It is combinational from registered state.
- Multiply:
  - Unsigned by default. Full 2*IN_W result, no truncation.
  - Valid bit and result are pipelined MUL_STAGES cycles.
  - An accepted pair appears on EN_writeMem/writeMem_val exactly MUL_STAGES cycles after the accepting edge.
- Write addressing:
  - Write pointer starts at 0 and increments after each write. The first product of a block is written to address 0.
  - count increments at accept, so in-flight products are counted.
  - Back-to-back accepts give one write per cycle.
- Transitions:
  - IDLE→FILL on first accept.
  - FILL→FULL when count reaches DEPTH.
  - IDLE/FILL/FULL→DRAIN when EN_blockRead=1, count>0 and the multiply pipeline is empty.
  - An EN_blockRead arriving while the pipeline is non-empty is held pending until the pipeline drains.
  - EN_blockRead with count=0 is ignored.
  - DRAIN→IDLE after the last VALID_memVal; count and write pointer clear to 0 on that transition.
- Simultaneous EN_mult and EN_blockRead: the read wins. RDY_mult drops the cycle after the request is registered. A pair accepted in the same edge is still written and is included in the drain.
- Drain:
  - EN_readMem=1 for count consecutive cycles, readMem_addr = 0..count-1.
  - VALID_memVal/memVal_data = readMem_val, registered once, so they follow each read by RD_LAT+1 cycles.
  - RDY_mult=0 throughout DRAIN.
- FULL holds indefinitely until a drain or reset; EN_mult is ignored.

Optional Feature:
- SIGNED_MULT_EN:
  - Defined: operands are two's-complement and the product is signed, 2*IN_W bits.
  - Undefined: unsigned multiply.
- Handshake and timing are identical in both builds.

Decomposition:
- Package mult_buf_pkg: state_t enum and a product-width helper function/localparam.
- One sub-module, mult_pipe (parametrised IN_W, MUL_STAGES, carries valid alongside data).
- FSM, pointers and drain sequencer stay in the top module.

Test Plan:
- Reset then 3 pairs (3×4, 65535×65535, 0×7), MUL_STAGES=2:
  - Writes at addr 0,1,2, each 2 cycles after accept.
  - Values 12, 0xFFFE0001, 0.
  - count=3.
- Fill 64 back-to-back pairs:
  - RDY_mult=0 after the 64th accept; state FULL.
  - A 65th EN_mult produces no write; last write at addr 63.
- After 5 writes, pulse EN_blockRead:
  - EN_readMem on addr 0..4.
  - 5 VALID_memVal beats matching the stored products, in order, RD_LAT+1 after each read.
  - Then IDLE, count=0, next write at addr 0.
- EN_blockRead on the same edge as an accept: that product is written and drained (count+1 beats).
- rst=0 mid-fill (2 products in flight):
  - No EN_writeMem afterwards; all outputs 0.
  - Next block starts at addr 0.
- SIGNED_MULT_EN build: (−3)×5 → writeMem_val=0xFFFFFFF1; unsigned build gives 0x0004FFF1.
